// File: rtl/ibfly_pipe_if.sv
// rtl/ibfly_pipe_if.sv - input/output stream bundle of the inverse butterfly pipe
interface ibfly_pipe_if #(
  parameter int DW = 25
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] s1;
  logic signed [DW-1:0] s2;
  logic [6:0]           i;
  logic [8:0]           n;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] r1;
  logic signed [DW-1:0] r2;
  logic                 err;

  modport master (
    output in_valid, s1, s2, i, n, out_ready,
    input  in_ready, out_valid, r1, r2, err
  );

  modport slave (
    input  in_valid, s1, s2, i, n, out_ready,
    output in_ready, out_valid, r1, r2, err
  );
endinterface

// File: rtl/ibfly_pipe.sv
// rtl/ibfly_pipe.sv - inverse DCT butterfly: r1=(s1+b)/2, r2=(s1-b)/2, b=s2*2cos
module ibfly_pipe #(
  parameter int DW = 25,
  parameter int CW = 16
) (
  input logic         clk,
  input logic         rst_n,
  ibfly_pipe_if.slave bus
);

  // Every legal (n,i) maps to angle k*pi/512 with k=(2i+1)*256/n, so one
  // quarter-wave table serves all spans. Entries built by integer Taylor series.
  function automatic logic [CW-1:0] cos_q15(input int k);
    logic [127:0] x, x2, term, sum;
    x    = (128'(k) * 128'h3243F6A8886) >> 9;
    x2   = (x * x) >> 40;
    term = 128'd1 << 40;
    sum  = term;
    for (int j = 1; j <= 10; j++) begin
      term = ((term * x2) >> 40) / 128'(2 * j * (2 * j - 1));
      if (j % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    return CW'((sum + (128'd1 << 24)) >> 25);
  endfunction

  logic [CW-1:0] cos_lut [256];
  for (genvar g = 0; g < 256; g++) begin : g_rom
    localparam logic [CW-1:0] CVAL = cos_q15(g);
    assign cos_lut[g] = CVAL;
  end

  logic en;
  logic legal, byp;
  logic [7:0] k;
  logic [CW-1:0] c_d;

  logic                 st1_vld_q, st1_byp_q, st1_err_q;
  logic signed [DW-1:0] st1_s1_q, st1_s2_q;
  logic [CW-1:0]        st1_c_q;
  logic                 st2_vld_q, st2_err_q;
  logic signed [DW-1:0] st2_s1_q;
  logic signed [DW:0]   st2_b_q;
  logic                 out_vld_q, err_q;
  logic signed [DW-1:0] r1_q, r2_q;

  assign en           = bus.out_ready | ~out_vld_q;
  assign bus.in_ready = en;

  always_comb begin
    legal = 1'b0;
    byp   = 1'b0;
    k     = '0;
    if (bus.n == 9'd1) begin
      legal = (bus.i == 7'd0);
      byp   = legal;
    end
    for (int p = 1; p <= 8; p++) begin
      if (bus.n == 9'(1 << p)) begin
        legal = ({1'b0, bus.i} < 8'(1 << (p - 1)));
        k     = 8'({bus.i, 1'b1} << (8 - p));
      end
    end
    c_d = (legal && !byp) ? cos_lut[k] : '0;
  end

  logic [DW-1:0]      mag;
  logic [DW+CW-1:0]   prod;
  logic [DW:0]        qmag;
  logic signed [DW:0] b_d;

  // Magnitude path so the rounding is symmetric about zero.
  always_comb begin
    mag  = st1_s2_q[DW-1] ? DW'(-st1_s2_q) : DW'(st1_s2_q);
    prod = (DW+CW)'(mag) * (DW+CW)'(st1_c_q);
    qmag = (DW+1)'((prod + (DW+CW)'(1 << (CW - 3))) >> (CW - 2));
    if (st1_byp_q)           b_d = {st1_s2_q[DW-1], st1_s2_q};
    else if (st1_s2_q[DW-1]) b_d = -$signed(qmag);
    else                     b_d = $signed(qmag);
  end

  function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] v);
    if (v[DW] != v[DW-1]) return {v[DW], {(DW-1){~v[DW]}}};
    return v[DW-1:0];
  endfunction

  logic signed [DW+1:0] t1, t2;
  logic signed [DW-1:0] r1_d, r2_d;

  always_comb begin
    t1   = (DW+2)'(st2_s1_q) + (DW+2)'(st2_b_q);
    t2   = (DW+2)'(st2_s1_q) - (DW+2)'(st2_b_q);
    r1_d = sat((DW+1)'(t1 >>> 1));
    r2_d = sat((DW+1)'(t2 >>> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st1_vld_q <= 1'b0;
      st1_byp_q <= 1'b0;
      st1_err_q <= 1'b0;
      st1_s1_q  <= '0;
      st1_s2_q  <= '0;
      st1_c_q   <= '0;
      st2_vld_q <= 1'b0;
      st2_err_q <= 1'b0;
      st2_s1_q  <= '0;
      st2_b_q   <= '0;
      out_vld_q <= 1'b0;
      err_q     <= 1'b0;
      r1_q      <= '0;
      r2_q      <= '0;
    end else if (en) begin
      st1_vld_q <= bus.in_valid;
      st1_byp_q <= byp;
      st1_err_q <= bus.in_valid & ~legal;
      st1_s1_q  <= bus.s1;
      st1_s2_q  <= bus.s2;
      st1_c_q   <= c_d;
      st2_vld_q <= st1_vld_q;
      st2_err_q <= st1_err_q;
      st2_s1_q  <= st1_s1_q;
      st2_b_q   <= b_d;
      out_vld_q <= st2_vld_q;
      err_q     <= st2_err_q;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.r1        = r1_q;
  assign bus.r2        = r2_q;
  assign bus.err       = err_q;

endmodule
